// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment 595 driver.
// Hex glyph table, serializer FSM encoding and bit phase length.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } hc_state_t;

  localparam int SHIFT_PH = 4;

  // gfedcba, lit = 1
  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7(
    input logic [3:0] n
  );
    return HEX_TAB[n];
  endfunction

endpackage

// File: rtl/seg_595_dynamic_hc595_ctrl.sv
// Serializer for two cascaded 74HC595: shifts a W-bit word MSB first,
// then pulses the storage latch; done marks the last latch cycle.
module hc595_ctrl
  import seg_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] word,
  input  logic         start,
  output logic         ds,
  output logic         shcp,
  output logic         stcp,
  output logic         done
);

  localparam int BW = $clog2(W);

  hc_state_t      state_q, state_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [1:0]     ph_q, ph_d;
  logic           ph_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
    end
  end

  assign ph_last = (ph_q == 2'(SHIFT_PH - 1));

  // Outputs decode straight from state so reset darkens pins at once.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    ds      = 1'b0;
    shcp    = 1'b0;
    stcp    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          bit_d   = '0;
          ph_d    = '0;
        end
      end
      SHIFT: begin
        ds   = word[(W - 1) - int'(bit_q)];
        shcp = ph_q[1];
        ph_d = ph_q + 2'd1;
        if (ph_last) begin
          if (bit_q == BW'(W - 1)) begin
            state_d = LATCH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      LATCH: begin
        stcp = 1'b1;
        ph_d = ph_q + 2'd1;
        if (ph_last) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/seg_595_dynamic.sv
// Multiplexed N-digit 7-segment driver over two cascaded 74HC595.
// Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
module seg_595_dynamic
  import seg_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SCAN_CNT       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  seg_en,
  input  logic                  data_vld,
  output logic                  ds,
  output logic                  shcp,
  output logic                  stcp,
  output logic                  oe
);

  localparam int W  = 8 + DIGITS;
  localparam int CW = $clog2(SCAN_CNT);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] sh_data, act_data;
  logic [DIGITS-1:0]   sh_dp, act_dp;
  logic                sh_en, act_en;

  logic [CW-1:0] slot_cnt;
  logic [IW-1:0] dig;
  logic          slot_end, frame_start;
  logic          busy, start, done;

  logic [3:0]        nib;
  logic [7:0]        seg_on, seg;
  logic [DIGITS-1:0] sel;
  logic [W-1:0]      word;

  assign slot_end    = (slot_cnt == CW'(SCAN_CNT - 1));
  assign frame_start = (slot_cnt == '0) && (dig == '0);
  assign start       = (slot_cnt == '0) && !busy;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      slot_cnt <= '0;
      dig      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      if (dig == IW'(DIGITS - 1)) begin
        dig <= '0;
      end else begin
        dig <= dig + 1'b1;
      end
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Active copy is taken only at frame start so one frame never mixes data.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_en    <= 1'b0;
      act_data <= '0;
      act_dp   <= '0;
      act_en   <= 1'b0;
      oe       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      oe <= 1'b0;
      if (data_vld) begin
        sh_data <= data;
        sh_dp   <= dp;
        sh_en   <= seg_en;
      end
      if (frame_start) begin
        act_data <= sh_data;
        act_dp   <= sh_dp;
        act_en   <= sh_en;
      end
      if (start) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic upper_zero;
  logic lz_blank;

  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(dig) && act_data[4*j +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
    lz_blank = (dig != '0) && upper_zero && !act_dp[dig];
  end
`endif

  always_comb begin
    nib      = act_data[4*dig +: 4];
    sel      = '0;
    sel[dig] = 1'b1;
    seg_on   = {act_dp[dig], hex7(nib)};
`ifdef SEG_LZ_BLANK_EN
    if (lz_blank) begin
      seg_on = '0;
    end
`endif
    if (!act_en) begin
      seg_on = '0;
    end
    seg  = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
    word = {seg, sel};
  end

  hc595_ctrl #(
    .W (W)
  ) u_ctrl (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .word  (word),
    .start (start),
    .ds    (ds),
    .shcp  (shcp),
    .stcp  (stcp),
    .done  (done)
  );

endmodule

// File: tb/tb_seg_595_dynamic.sv
// Bench for seg_595_dynamic: decodes latched 595 words off the pins
// and compares them with a queue of expected words.
module tb_seg_595_dynamic;

  localparam int DIGITS   = 6;
  localparam int SCAN_CNT = 100;
  localparam int W        = 14;

  logic        sys_clk  = 1'b0;
  logic        sys_rst  = 1'b1;
  logic [23:0] data     = '0;
  logic [5:0]  dp       = '0;
  logic        seg_en   = 1'b0;
  logic        data_vld = 1'b0;
  logic        ds, shcp, stcp, oe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] sreg    = '0;
  logic [W-1:0] exp_w;
  int           nbits   = 0;
  logic         sh_prev = 1'b0;
  logic         st_prev = 1'b0;

  always #5 sys_clk = ~sys_clk;

  seg_595_dynamic #(
    .DIGITS         (DIGITS),
    .SCAN_CNT       (SCAN_CNT),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .data     (data),
    .dp       (dp),
    .seg_en   (seg_en),
    .data_vld (data_vld),
    .ds       (ds),
    .shcp     (shcp),
    .stcp     (stcp),
    .oe       (oe)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex_ref(
    input logic [3:0] n
  );
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_word(
    input logic [23:0] d,
    input logic [5:0]  p,
    input logic        en,
    input int          i
  );
    logic [7:0] on;
    logic [5:0] sel;
    on = {p[i], hex_ref(d[4*i +: 4])};
`ifdef SEG_LZ_BLANK_EN
    if (i > 0 && (d >> (4*i)) == 24'd0 && !p[i])
      on = 8'h00;
`endif
    if (!en) on = 8'h00;
    sel = 6'b000001 << i;
    return {~on, sel};
  endfunction

  task automatic push_frame(
    input logic [23:0] d,
    input logic [5:0]  p,
    input logic        en,
    input int          first,
    input int          last
  );
    for (int i = first; i <= last; i++)
      exp_q.push_back(exp_word(d, p, en, i));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      cyc++;
    end
    #1;
  endtask

  task automatic wait_to(input int c);
    step(c - cyc);
  endtask

  task automatic load(
    input logic [23:0] d,
    input logic [5:0]  p,
    input logic        en
  );
    data     = d;
    dp       = p;
    seg_en   = en;
    data_vld = 1'b1;
    step(1);
    data_vld = 1'b0;
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      sh_prev = 1'b0;
      st_prev = 1'b0;
      nbits   = 0;
    end else begin
      if (shcp && !sh_prev) begin
        sreg = {sreg[W-2:0], ds};
        nbits++;
      end
      if (stcp && !st_prev) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL latch_unexpected observed=%h expected=none",
                 sreg);
        end
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          chk("latch_word", 32'(sreg), 32'(exp_w));
          chk("latch_bits", nbits, W);
        end
        nbits = 0;
      end
      sh_prev = shcp;
      st_prev = stcp;
    end
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_ds", ds, 1'b0);
    chk("rst_shcp", shcp, 1'b0);
    chk("rst_stcp", stcp, 1'b0);
    chk("rst_oe", oe, 1'b1);

    @(negedge sys_clk);
    sys_rst = 1'b0;
    cyc     = 0;
    #1;
    chk("oe_pre_edge", oe, 1'b1);
    push_frame(24'h0, 6'h0, 1'b0, 0, 5);
    step(1);
    chk("oe_low", oe, 1'b0);
    step(1);
    chk("shcp_c2", shcp, 1'b0);
    step(1);
    chk("shcp_c3", shcp, 1'b1);
    wait_to(56);
    chk("stcp_c56", stcp, 1'b0);
    for (int c = 57; c <= 60; c++) begin
      step(1);
      chk("stcp_hi", stcp, 1'b1);
    end
    for (int c = 61; c <= 99; c++) begin
      step(1);
      chk("idle_pins", {ds, shcp, stcp}, 3'b000);
    end

    wait_to(300);
    load(24'h123456, 6'b000100, 1'b1);
    push_frame(24'h123456, 6'b000100, 1'b1, 0, 5);

    wait_to(1200);
    load(24'hABCDEF, 6'b100001, 1'b1);
    push_frame(24'h123456, 6'b000100, 1'b1, 0, 5);
    push_frame(24'hABCDEF, 6'b100001, 1'b1, 0, 5);

    wait_to(2100);
    load(24'h987654, 6'b111111, 1'b0);
    push_frame(24'h987654, 6'b111111, 1'b0, 0, 5);

    wait_to(3000);
    push_frame(24'h987654, 6'b111111, 1'b0, 0, 0);

    wait_to(3120);
    chk("mid_shcp", shcp, 1'b1);
    chk("mid_queue", exp_q.size(), 0);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_ds", ds, 1'b0);
    chk("arst_shcp", shcp, 1'b0);
    chk("arst_stcp", stcp, 1'b0);
    chk("arst_oe", oe, 1'b1);

    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cyc     = 0;
    push_frame(24'h0, 6'h0, 1'b0, 0, 5);
    step(1);
    chk("re_oe_low", oe, 1'b0);
    step(2);
    chk("re_shcp_c3", shcp, 1'b1);

    wait_to(300);
    load(24'h000050, 6'b000000, 1'b1);
    push_frame(24'h000050, 6'b000000, 1'b1, 0, 5);

    wait_to(900);
    load(24'h000000, 6'b000000, 1'b1);
    push_frame(24'h000000, 6'b000000, 1'b1, 0, 5);

    wait_to(1800);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
